// File: rtl/c_icache_responder.sv
// Direct-mapped fetch-side instruction cache with 4-word line refill over a burst memory port.
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit_cnt / miss_cnt outputs.
module c_icache_responder #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cache_request,
  input  logic              i_cache_req_kill,
  input  logic              i_cache_flush,
  input  logic [ADDR_W-1:0] addr,
  output logic              i_cache_ready,
  output logic              i_cache_valid,
  output logic [31:0]       inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_RESP, S_MREQ, S_REFILL, S_FILLRESP, S_PEND
  } state_t;

  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*4];

  logic [WA_W-1:0]  req_w;
  logic [WA_W-1:0]  pend_w;
  logic             pend_valid;
  logic             killed;
  logic             fill_inval;
  logic             held;
  logic [1:0]       beat;
  logic [31:0]      inst_q;

  logic             cancel;
  logic             new_req;
  logic             lookup_en;
  logic [WA_W-1:0]  lk_w;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             last_beat;
  logic             pend_nxt;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      rd_word;
  logic             unused_ok;

  assign unused_ok = &{1'b0, addr[1:0]};

  assign cancel    = i_cache_req_kill | i_cache_flush;
  assign new_req   = i_cache_request & cancel;
  assign req_idx   = req_w[2 +: IDX_W];
  assign rd_word   = data_q[{req_idx, req_w[1:0]}];
  assign last_beat = (state == S_REFILL) && mem_rvalid && (beat == 2'd3);
  assign pend_nxt  = new_req ? 1'b1 : (cancel ? 1'b0 : pend_valid);

  // A request still held high after its own acceptance is not taken again;
  // kill/flush alongside it marks it as a fresh request.
  always_comb begin
    lookup_en = 1'b0;
    lk_w      = addr[ADDR_W-1:2];
    case (state)
      S_IDLE:               lookup_en = i_cache_request & (~held | cancel);
      S_RESP, S_FILLRESP:   lookup_en = new_req;
      S_PEND: begin
        lookup_en = new_req | ~cancel;
        lk_w      = new_req ? addr[ADDR_W-1:2] : pend_w;
      end
      default:              lookup_en = 1'b0;
    endcase
  end

  assign lk_idx = lk_w[2 +: IDX_W];
  assign lk_tag = lk_w[WA_W-1 -: TAG_W];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !i_cache_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RESP, S_FILLRESP, S_PEND: begin
        if (lookup_en) state_nxt = lk_hit ? S_RESP : S_MREQ;
        else           state_nxt = S_IDLE;
      end
      S_MREQ:   if (mem_ack) state_nxt = S_REFILL;
      S_REFILL: begin
        if (last_beat) begin
          if (killed | cancel) state_nxt = pend_nxt ? S_PEND : S_IDLE;
          else                 state_nxt = S_FILLRESP;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    i_cache_ready = (state == S_IDLE) & ~lookup_en;
    i_cache_valid = ((state == S_RESP) || (state == S_FILLRESP)) & ~cancel;
    mem_req       = (state == S_MREQ);
    inst          = i_cache_valid ? rd_word : inst_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      req_w      <= '0;
      pend_w     <= '0;
      pend_valid <= 1'b0;
      killed     <= 1'b0;
      fill_inval <= 1'b0;
      held       <= 1'b0;
      beat       <= 2'd0;
      inst_q     <= 32'd0;
      mem_addr   <= '0;
    end else begin
      held <= i_cache_request & (held | lookup_en);
      if (i_cache_valid) inst_q <= rd_word;

      if (lookup_en) begin
        req_w      <= lk_w;
        killed     <= 1'b0;
        fill_inval <= 1'b0;
        pend_valid <= 1'b0;
        if (!lk_hit) mem_addr <= {lk_w[WA_W-1:2], 4'b0000};
      end

      if ((state == S_MREQ) || (state == S_REFILL)) begin
        if (cancel) begin
          killed     <= 1'b1;
          pend_valid <= new_req;
        end
        if (new_req)       pend_w     <= addr[ADDR_W-1:2];
        if (i_cache_flush) fill_inval <= 1'b1;
      end

      if ((state == S_MREQ) && mem_ack)      beat <= 2'd0;
      else if ((state == S_REFILL) && mem_rvalid) beat <= beat + 2'd1;

      // The line being refilled is invalid until its last beat lands.
      if (i_cache_flush)         valid_q          <= '0;
      if (lookup_en && !lk_hit)  valid_q[lk_idx]  <= 1'b0;
      if (last_beat)             valid_q[req_idx] <= ~(fill_inval | i_cache_flush);
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_REFILL) && mem_rvalid) data_q[{req_idx, beat}] <= mem_rdata;
    if (last_beat) tag_q[req_idx] <= req_w[WA_W-1 -: TAG_W];
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (lookup_en) begin
      if (lk_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_c_icache_responder.sv
// Directed and randomized bench for c_icache_responder against a line-level cache model.
module tb_c_icache_responder;
  localparam int NL = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        request, kill, flush;
  logic [31:0] addr;
  logic        ready, valid;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model: which line address each index currently holds, plus backing memory.
  bit          mv [NL];
  logic [31:0] mt [NL];
  logic [31:0] memw [logic [31:0]];

  always #5 clk = ~clk;

  c_icache_responder #(.NUM_LINES(NL), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_cache_request(request), .i_cache_req_kill(kill), .i_cache_flush(flush),
    .addr(addr), .i_cache_ready(ready), .i_cache_valid(valid), .inst(inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] line, input int b);
    logic [31:0] k;
    k = line + 32'(b * 4);
    if (!memw.exists(k)) memw[k] = $urandom;
    return memw[k];
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[9:4]);
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
  endtask

  // Memory side: ack after a random delay, then 4 beats with random gaps.
  // One gap cycle before beat inj_at may carry request/kill/flush.
  task automatic serve(input logic [31:0] line, input int inj_at, input bit inj_req,
                       input bit inj_kill, input bit inj_flush, input logic [31:0] inj_addr);
    int d, g;
    d = $urandom_range(0, 2);
    repeat (d) begin
      cyc();
      #1 check("mreq_hold", {31'd0, mem_req, mem_addr}, {31'd1, line});
    end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(0, 2);
      if (b == inj_at && g == 0) g = 1;
      for (int j = 0; j < g; j++) begin
        if (b == inj_at && j == 0) begin
          request = inj_req; kill = inj_kill; flush = inj_flush; addr = inj_addr;
          if (inj_flush) model_flush();
        end
        #1 check("refill_quiet", {63'd0, valid}, 64'd0);
        cyc();
        request = 1'b0; kill = 1'b0; flush = 1'b0;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = word(line, b);
      cyc();
      mem_rvalid = 1'b0;
    end
    if (!(inj_at >= 0 && inj_flush)) begin
      mv[idx_of(line)] = 1'b1;
      mt[idx_of(line)] = line;
    end
  endtask

  // One plain fetch, starting at the beginning of a cycle; hit/miss from the model.
  task automatic fetch(input logic [31:0] a, input bit with_flush);
    logic [31:0] line;
    bit          hit;
    line = a & ~32'hF;
    if (with_flush) model_flush();
    hit = mv[idx_of(a)] && (mt[idx_of(a)] == line);
    request = 1'b1; addr = a; flush = with_flush;
    #1 check("ready_at_accept", {63'd0, ready}, 64'd0);
    cyc();
    request = 1'b0; flush = 1'b0;
    #1;
    if (hit) begin
      check("hit_valid", {63'd0, valid}, 64'd1);
      check("hit_inst", {32'd0, inst}, {32'd0, word(line, int'(a[3:2]))});
      check("hit_no_mreq", {63'd0, mem_req}, 64'd0);
    end else begin
      check("miss_novalid", {63'd0, valid}, 64'd0);
      check("miss_mreq", {31'd0, mem_req, mem_addr}, {31'd1, line});
      serve(line, -1, 1'b0, 1'b0, 1'b0, 32'd0);
      #1 check("fill_valid", {63'd0, valid}, 64'd1);
      check("fill_inst", {32'd0, inst}, {32'd0, word(line, int'(a[3:2]))});
    end
    cyc();
  endtask

  initial begin
    int pulses;
    logic [31:0] ra;
    reset = 1'b1; request = 1'b0; kill = 1'b0; flush = 1'b0; addr = 32'd0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    memw[32'h100] = 32'hA0; memw[32'h104] = 32'hA1;
    memw[32'h108] = 32'hA2; memw[32'h10C] = 32'hA3;
    model_flush();

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_inst", {32'd0, inst}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    #2 reset = 1'b0;
    cyc();

    // cold miss, hit, misaligned
    fetch(32'h100, 1'b0);
    fetch(32'h10C, 1'b0);
    fetch(32'h102, 1'b0);
    fetch(32'h10E, 1'b0);

    // request held high for three cycles on a hit
    pulses = 0;
    request = 1'b1; addr = 32'h108;
    #1 check("held_ready_n", {63'd0, ready}, 64'd0);
    cyc();
    #1 check("held_ready_n1", {63'd0, ready}, 64'd0);
    check("held_inst", {32'd0, inst}, 64'hA2);
    pulses += int'(valid);
    cyc();
    #1 pulses += int'(valid);
    cyc();
    request = 1'b0;
    #1 pulses += int'(valid);
    cyc();
    #1 pulses += int'(valid);
    check("held_one_pulse", 64'(pulses), 64'd1);
    cyc();

    // flush in IDLE, then 0x100 misses; kill+request 0x200 during its refill
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    model_flush();
    request = 1'b1; addr = 32'h100;
    cyc();
    request = 1'b0;
    #1 check("flush_then_miss", {31'd0, mem_req, mem_addr}, {31'd1, 32'h100});
    serve(32'h100, 1, 1'b1, 1'b1, 1'b0, 32'h200);
    #1 check("kill_no_resp", {63'd0, valid}, 64'd0);
    cyc();
    #1 check("pend_mreq", {31'd0, mem_req, mem_addr}, {31'd1, 32'h200});
    serve(32'h200, -1, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 check("pend_valid", {63'd0, valid}, 64'd1);
    check("pend_inst", {32'd0, inst}, {32'd0, word(32'h200, 0)});
    cyc();
    fetch(32'h104, 1'b0);

    // flush during refill of 0x300
    request = 1'b1; addr = 32'h300;
    cyc();
    request = 1'b0;
    #1 check("m300_mreq", {31'd0, mem_req, mem_addr}, {31'd1, 32'h300});
    serve(32'h300, 2, 1'b0, 1'b0, 1'b1, 32'd0);
    #1 check("flush_no_resp", {63'd0, valid}, 64'd0);
    check("flush_ready", {63'd0, ready}, 64'd1);
    cyc();
    fetch(32'h300, 1'b0);
    fetch(32'h308, 1'b1);

    // kill alone in RESP, then kill+request in RESP
    request = 1'b1; addr = 32'h304;
    cyc();
    request = 1'b0; kill = 1'b1;
    #1 check("kill_resp", {63'd0, valid}, 64'd0);
    cyc();
    kill = 1'b0;
    request = 1'b1; addr = 32'h304;
    cyc();
    kill = 1'b1; addr = 32'h30C;
    #1 check("kill_req_resp", {63'd0, valid}, 64'd0);
    cyc();
    kill = 1'b0; request = 1'b0;
    #1 check("kill_req_valid", {63'd0, valid}, 64'd1);
    check("kill_req_inst", {32'd0, inst}, {32'd0, word(32'h300, 3)});
    cyc();
    #1 check("inst_held", {32'd0, inst}, {32'd0, word(32'h300, 3)});

    // random fetches over a small set of conflicting lines
    for (int i = 0; i < 40; i++) begin
      ra = 32'h1000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 3) << 4)
           + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      fetch(ra, ($urandom_range(0, 7) == 0));
    end

    // async reset between refill beats
    fetch(32'h100, 1'b0);
    request = 1'b1; addr = 32'h400;
    cyc();
    request = 1'b0;
    #1 check("m400_mreq", {31'd0, mem_req, mem_addr}, {31'd1, 32'h400});
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11;
    cyc();
    mem_rdata = 32'h22;
    cyc();
    mem_rvalid = 1'b0;
    #2 reset = 1'b1;
    #1 check("rstmid_mem_req", {63'd0, mem_req}, 64'd0);
    check("rstmid_ready", {63'd0, ready}, 64'd1);
    check("rstmid_valid", {63'd0, valid}, 64'd0);
    #1 reset = 1'b0;
    model_flush();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h33;
    cyc();
    cyc();
    mem_rvalid = 1'b0;
    #1 check("stray_beats", {62'd0, mem_req, valid}, 64'd0);
    cyc();
    fetch(32'h100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
